// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  localparam logic [2:0] DEFAULT_FUNCT3 = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core, loader and shared memory port signal bundle
interface mem_port_arbiter_if;

  logic        c_req;
  logic        c_wren;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_funct3;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;

  logic        l_req;
  logic        l_wren;
  logic        l_lock;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [2:0]  l_funct3;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;

  logic        m_wren;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_funct3;
  logic [31:0] m_rdata;

  // arbiter side
  modport slave (
    input  c_req, c_wren, c_addr, c_wdata, c_funct3,
    output c_gnt, c_rvalid, c_rdata,
    input  l_req, l_wren, l_lock, l_addr, l_wdata, l_funct3,
    output l_gnt, l_rvalid, l_rdata,
    output m_wren, m_addr, m_wdata, m_funct3,
    input  m_rdata
  );

  // requesters and memory side
  modport master (
    output c_req, c_wren, c_addr, c_wdata, c_funct3,
    input  c_gnt, c_rvalid, c_rdata,
    output l_req, l_wren, l_lock, l_addr, l_wdata, l_funct3,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_wren, m_addr, m_wdata, m_funct3,
    output m_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick with loader lock and last-grant register
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_core,
  input  logic req_ldr,
  input  logic lock,
  output logic gnt_core,
  output logic gnt_ldr
);

  owner_t last_grant;

  always_comb begin
    gnt_core = 1'b0;
    gnt_ldr  = 1'b0;
    if (!reset) begin
      if (lock) begin
        gnt_ldr = req_ldr;
      end else if (req_core && req_ldr) begin
        // tie goes to whoever was not served last
        if (last_grant == OWN_CORE) gnt_ldr = 1'b1;
        else                        gnt_core = 1'b1;
      end else begin
        gnt_core = req_core;
        gnt_ldr  = req_ldr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         last_grant <= OWN_LDR;
    else if (gnt_core) last_grant <= OWN_CORE;
    else if (gnt_ldr)  last_grant <= OWN_LDR;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between core and loader, one read in flight
module mem_port_arbiter #(
  parameter logic [2:0] DEFAULT_FUNCT3 = mem_arb_pkg::DEFAULT_FUNCT3
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  owner_t      pending;
  owner_t      pending_next;
  logic        lock_active;
  logic        lock_eff;
  logic        gnt_core;
  logic        gnt_ldr;
  logic [31:0] c_rdata_q;
  logic [31:0] l_rdata_q;

  // dropping l_lock releases the bus in that same cycle
  assign lock_eff = lock_active & bus.l_lock;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req_core (bus.c_req),
    .req_ldr  (bus.l_req),
    .lock     (lock_eff),
    .gnt_core (gnt_core),
    .gnt_ldr  (gnt_ldr)
  );

  assign bus.c_gnt = gnt_core;
  assign bus.l_gnt = gnt_ldr;

  always_comb begin
    bus.m_wren   = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.m_funct3 = DEFAULT_FUNCT3;
    if (gnt_core) begin
      bus.m_wren   = bus.c_wren;
      bus.m_addr   = bus.c_addr;
      bus.m_wdata  = bus.c_wdata;
      bus.m_funct3 = bus.c_funct3;
    end else if (gnt_ldr) begin
      bus.m_wren   = bus.l_wren;
      bus.m_addr   = bus.l_addr;
      bus.m_wdata  = bus.l_wdata;
      bus.m_funct3 = bus.l_funct3;
    end
  end

  always_comb begin
    pending_next = OWN_NONE;
    if (gnt_core && !bus.c_wren)     pending_next = OWN_CORE;
    else if (gnt_ldr && !bus.l_wren) pending_next = OWN_LDR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= OWN_NONE;
      lock_active <= 1'b0;
      c_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      pending <= pending_next;
      if (gnt_ldr && bus.l_lock) lock_active <= 1'b1;
      else if (!bus.l_lock)      lock_active <= 1'b0;
      if (pending == OWN_CORE) c_rdata_q <= bus.m_rdata;
      if (pending == OWN_LDR)  l_rdata_q <= bus.m_rdata;
    end
  end

  // the returning word is passed straight through, then held
  assign bus.c_rvalid = (pending == OWN_CORE);
  assign bus.l_rvalid = (pending == OWN_LDR);
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : c_rdata_q;
  assign bus.l_rdata  = bus.l_rvalid ? bus.m_rdata : l_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table, reset corner case and random run against a reference model
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.DEFAULT_FUNCT3(3'b010)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [31:0] C_WD = 32'h1234_5678;
  localparam logic [31:0] L_WD = 32'hDEAD_BEEF;
  localparam logic [2:0]  C_F3 = 3'b001;
  localparam logic [2:0]  L_F3 = 3'b000;
  localparam logic [2:0]  IDLE_F3 = 3'b010;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory returns data one cycle after the address
  always @(posedge clk) bus.m_rdata <= rom(bus.m_addr);

  int passed = 0;
  int total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic e_cg, input logic e_lg, input logic e_mw,
                           input logic [31:0] e_maddr, input logic [31:0] e_mwd, input logic [2:0] e_mf3,
                           input logic e_crv, input logic e_lrv, input logic [31:0] e_crd, input logic [31:0] e_lrd);
    check({tag, " c_gnt"},    32'(bus.c_gnt),    32'(e_cg));
    check({tag, " l_gnt"},    32'(bus.l_gnt),    32'(e_lg));
    check({tag, " m_wren"},   32'(bus.m_wren),   32'(e_mw));
    check({tag, " m_addr"},   bus.m_addr,        e_maddr);
    check({tag, " m_wdata"},  bus.m_wdata,       e_mwd);
    check({tag, " m_funct3"}, 32'(bus.m_funct3), 32'(e_mf3));
    check({tag, " c_rvalid"}, 32'(bus.c_rvalid), 32'(e_crv));
    check({tag, " l_rvalid"}, 32'(bus.l_rvalid), 32'(e_lrv));
    check({tag, " c_rdata"},  bus.c_rdata,       e_crd);
    check({tag, " l_rdata"},  bus.l_rdata,       e_lrd);
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                       input logic lr, input logic lw, input logic ll, input logic [31:0] la);
    bus.c_req = cr; bus.c_wren = cw; bus.c_addr = ca; bus.c_wdata = C_WD; bus.c_funct3 = C_F3;
    bus.l_req = lr; bus.l_wren = lw; bus.l_lock = ll; bus.l_addr = la;
    bus.l_wdata = L_WD; bus.l_funct3 = L_F3;
  endtask

  typedef struct {
    logic        c_req, c_wren;
    logic [31:0] c_addr;
    logic        l_req, l_wren, l_lock;
    logic [31:0] l_addr;
    logic        e_cg, e_lg, e_mw;
    logic [31:0] e_maddr, e_mwd;
    logic [2:0]  e_mf3;
    logic        e_crv, e_lrv;
    logic [31:0] e_crd, e_lrd;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] cr, cw, ca, lr, lw, ll, la,
                              input logic [31:0] cg, lg, mw, ma, md, mf, crv, lrv, crd, lrd);
    vec_t v;
    v.c_req = cr[0]; v.c_wren = cw[0]; v.c_addr = ca;
    v.l_req = lr[0]; v.l_wren = lw[0]; v.l_lock = ll[0]; v.l_addr = la;
    v.e_cg = cg[0]; v.e_lg = lg[0]; v.e_mw = mw[0]; v.e_maddr = ma; v.e_mwd = md;
    v.e_mf3 = mf[2:0]; v.e_crv = crv[0]; v.e_lrv = lrv[0]; v.e_crd = crd; v.e_lrd = lrd;
    return v;
  endfunction

  vec_t tbl[14];

  // reference model state
  bit          core_was_last;
  bit          lock_m;
  int          infl_owner;
  logic [31:0] infl_addr;
  logic [31:0] hold_c, hold_l;

  initial begin
    logic        c_act, l_act;
    int          win;
    logic        e_crv, e_lrv;
    logic [31:0] e_crd, e_lrd;

    tbl[0]  = mk(0,0,0,      0,0,0,0,      0,0,0, 0,0,IDLE_F3,          0,0, 0,0);
    tbl[1]  = mk(1,0,'h1000, 1,0,0,'h2000, 1,0,0, 'h1000,C_WD,C_F3,     0,0, 0,0);
    tbl[2]  = mk(0,0,0,      1,0,0,'h2000, 0,1,0, 'h2000,L_WD,L_F3,     1,0, 'hC0DE1000,0);
    tbl[3]  = mk(0,0,0,      0,0,0,0,      0,0,0, 0,0,IDLE_F3,          0,1, 'hC0DE1000,'hC0DE2000);
    tbl[4]  = mk(0,0,0,      0,0,0,0,      0,0,0, 0,0,IDLE_F3,          0,0, 'hC0DE1000,'hC0DE2000);
    tbl[5]  = mk(1,0,'h1000, 0,0,0,0,      1,0,0, 'h1000,C_WD,C_F3,     0,0, 'hC0DE1000,'hC0DE2000);
    tbl[6]  = mk(1,0,'h1004, 0,0,0,0,      1,0,0, 'h1004,C_WD,C_F3,     1,0, 'hC0DE1000,'hC0DE2000);
    tbl[7]  = mk(1,0,'h1008, 0,0,0,0,      1,0,0, 'h1008,C_WD,C_F3,     1,0, 'hC0DE1004,'hC0DE2000);
    tbl[8]  = mk(0,0,0,      0,0,0,0,      0,0,0, 0,0,IDLE_F3,          1,0, 'hC0DE1008,'hC0DE2000);
    tbl[9]  = mk(1,0,'h1010, 1,1,1,'h2004, 0,1,1, 'h2004,L_WD,L_F3,     0,0, 'hC0DE1008,'hC0DE2000);
    tbl[10] = mk(1,0,'h1010, 1,1,1,'h2004, 0,1,1, 'h2004,L_WD,L_F3,     0,0, 'hC0DE1008,'hC0DE2000);
    tbl[11] = mk(1,0,'h1010, 1,1,1,'h2004, 0,1,1, 'h2004,L_WD,L_F3,     0,0, 'hC0DE1008,'hC0DE2000);
    tbl[12] = mk(1,0,'h1010, 0,0,0,0,      1,0,0, 'h1010,C_WD,C_F3,     0,0, 'hC0DE1008,'hC0DE2000);
    tbl[13] = mk(0,0,0,      0,0,0,0,      0,0,0, 0,0,IDLE_F3,          1,0, 'hC0DE1010,'hC0DE2000);

    // no grant while reset is high, even with both requesting
    drive(1, 0, 32'h40, 1, 0, 0, 32'h80);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    check_all("in_reset", 0, 0, 0, 0, 0, IDLE_F3, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].c_req, tbl[i].c_wren, tbl[i].c_addr, tbl[i].l_req, tbl[i].l_wren, tbl[i].l_lock, tbl[i].l_addr);
      #2;
      check_all($sformatf("vec%0d", i), tbl[i].e_cg, tbl[i].e_lg, tbl[i].e_mw, tbl[i].e_maddr, tbl[i].e_mwd,
                tbl[i].e_mf3, tbl[i].e_crv, tbl[i].e_lrv, tbl[i].e_crd, tbl[i].e_lrd);
    end

    // read granted, reset in the following cycle: the read is lost
    @(negedge clk);
    drive(1, 0, 32'h1020, 0, 0, 0, 0);
    #2;
    check("rst_rd c_gnt", 32'(bus.c_gnt), 1);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("rst_rd c_rvalid during", 32'(bus.c_rvalid), 0);
    check("rst_rd c_gnt during", 32'(bus.c_gnt), 0);
    check("rst_rd c_rdata cleared", bus.c_rdata, 0);
    check("rst_rd l_rdata cleared", bus.l_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_rd c_rvalid after", 32'(bus.c_rvalid), 0);
    @(negedge clk);
    #2;
    check("rst_rd c_rvalid later", 32'(bus.c_rvalid), 0);
    check("rst_rd l_rvalid later", 32'(bus.l_rvalid), 0);

    // random traffic against the reference model
    core_was_last = 1'b0;
    lock_m = 1'b0;
    infl_owner = 0;
    infl_addr = '0;
    hold_c = '0;
    hold_l = '0;
    c_act = 1'b0;
    l_act = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!c_act && $urandom_range(0, 1) == 1) begin
        c_act = 1'b1;
        bus.c_wren = 1'($urandom_range(0, 1));
        bus.c_addr = $urandom & 32'h0000_FFFC;
        bus.c_wdata = $urandom;
        bus.c_funct3 = 3'($urandom_range(0, 7));
      end
      if (!l_act && $urandom_range(0, 2) != 0) begin
        l_act = 1'b1;
        bus.l_wren = 1'($urandom_range(0, 1));
        bus.l_lock = ($urandom_range(0, 3) == 0);
        bus.l_addr = $urandom & 32'h0000_FFFC;
        bus.l_wdata = $urandom;
        bus.l_funct3 = 3'($urandom_range(0, 7));
      end
      if (!l_act) bus.l_lock = 1'b0;
      bus.c_req = c_act;
      bus.l_req = l_act;

      // winner: lock favours loader, otherwise the one not served last
      if (c_act && l_act) win = (lock_m && bus.l_lock) ? 2 : (core_was_last ? 2 : 1);
      else if (c_act)     win = (lock_m && bus.l_lock) ? 0 : 1;
      else if (l_act)     win = 2;
      else                win = 0;

      e_crv = (infl_owner == 1);
      e_lrv = (infl_owner == 2);
      e_crd = e_crv ? rom(infl_addr) : hold_c;
      e_lrd = e_lrv ? rom(infl_addr) : hold_l;
      #2;
      if (win == 1)
        check_all($sformatf("rnd%0d", cyc), 1, 0, bus.c_wren, bus.c_addr, bus.c_wdata, bus.c_funct3,
                  e_crv, e_lrv, e_crd, e_lrd);
      else if (win == 2)
        check_all($sformatf("rnd%0d", cyc), 0, 1, bus.l_wren, bus.l_addr, bus.l_wdata, bus.l_funct3,
                  e_crv, e_lrv, e_crd, e_lrd);
      else
        check_all($sformatf("rnd%0d", cyc), 0, 0, 0, 0, 0, IDLE_F3, e_crv, e_lrv, e_crd, e_lrd);

      hold_c = e_crd;
      hold_l = e_lrd;
      if (win == 2 && bus.l_lock) lock_m = 1'b1;
      else if (!bus.l_lock)       lock_m = 1'b0;
      infl_owner = 0;
      if (win == 1) begin
        core_was_last = 1'b1;
        c_act = 1'b0;
        if (!bus.c_wren) begin infl_owner = 1; infl_addr = bus.c_addr; end
      end else if (win == 2) begin
        core_was_last = 1'b0;
        l_act = 1'b0;
        if (!bus.l_wren) begin infl_owner = 2; infl_addr = bus.l_addr; end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
